morse_tx: RTL and testbench

- Morse transmitter for the game: plays one letter pattern on an LED/buzzer line.
- The time base is a one-cycle unit-tick pulse from the existing 100 ms prescaler.
- Sits between the letter ROM and the output pin. It is the sending counterpart to the button-side Morse receiver and its tick-counting timeout logic.
- Letters are loaded via valid/ready; a one-cycle Done pulse reports the end of each letter, including its trailing letter gap.

---
 rtl/morse_pkg.sv | 43 ++++
 rtl/morse_if.sv | 17 +
 rtl/morse_unit_timer.sv | 39 +++
 rtl/morse_tx.sv | 143 ++++++++++++++
 tb/tb_morse_tx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Purpose: shared constants for the Morse transmitter slice. It holds the FSM
//          state encoding, the timing units and the letter ROM.
// Contents:
//   MAX_LEN, *_UNITS       symbol limit and mark/space lengths in unit ticks
//   ST_*                   FSM state encoding (3-bit, legacy-compatible)
//   MORSE_ROM / morse_pattern()
//                          {len[7:5], bits[4:0]} for A..Z (0..25) and 0..9 (26..35);
//                          bit0 of bits is sent first, 1 = dash
package morse_pkg;

  localparam int MAX_LEN          = 5;
  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int SYM_GAP_UNITS    = 1;
  localparam int LETTER_GAP_UNITS = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_MARK = 3'd2;
  localparam logic [2:0] ST_SGAP = 3'd3;
  localparam logic [2:0] ST_LGAP = 3'd4;

  typedef logic [7:0] morse_pat_t;

  localparam morse_pat_t MORSE_ROM [36] = '{
    {3'd2, 5'b00010}, {3'd4, 5'b00001}, {3'd4, 5'b00101}, {3'd3, 5'b00001}, // A B C D
    {3'd1, 5'b00000}, {3'd4, 5'b00100}, {3'd3, 5'b00011}, {3'd4, 5'b00000}, // E F G H
    {3'd2, 5'b00000}, {3'd4, 5'b01110}, {3'd3, 5'b00101}, {3'd4, 5'b00010}, // I J K L
    {3'd2, 5'b00011}, {3'd2, 5'b00001}, {3'd3, 5'b00111}, {3'd4, 5'b00110}, // M N O P
    {3'd4, 5'b01011}, {3'd3, 5'b00010}, {3'd3, 5'b00000}, {3'd1, 5'b00001}, // Q R S T
    {3'd3, 5'b00100}, {3'd4, 5'b01000}, {3'd3, 5'b00110}, {3'd4, 5'b01001}, // U V W X
    {3'd4, 5'b01101}, {3'd4, 5'b00011},                                     // Y Z
    {3'd5, 5'b11111}, {3'd5, 5'b11110}, {3'd5, 5'b11100}, {3'd5, 5'b11000}, // 0 1 2 3
    {3'd5, 5'b10000}, {3'd5, 5'b00000}, {3'd5, 5'b00001}, {3'd5, 5'b00011}, // 4 5 6 7
    {3'd5, 5'b00111}, {3'd5, 5'b01111}                                      // 8 9
  };

  // Out-of-range indices return an empty pattern (pure letter gap).
  function automatic morse_pat_t morse_pattern(input logic [5:0] idx);
    return (idx < 6'd36) ? MORSE_ROM[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/morse_if.sv
// Purpose: letter-load channel between the letter ROM side and morse_tx.
// Signals:
//   LoadValid  master->slave  SymLen/SymBits valid
//   LoadReady  slave->master  transmitter can accept a letter
//   SymLen     master->slave  number of symbols, 0..MAX_LEN (larger is clamped)
//   SymBits    master->slave  pattern, bit0 first, 1 = dash
interface morse_if;
  import morse_pkg::*;

  logic               LoadValid;
  logic               LoadReady;
  logic [2:0]         SymLen;
  logic [MAX_LEN-1:0] SymBits;

  modport master (output LoadValid, SymLen, SymBits, input LoadReady);
  modport slave  (input LoadValid, SymLen, SymBits, output LoadReady);
endinterface

// File: rtl/morse_unit_timer.sv
// Purpose: counts unit ticks and fires a one-cycle expire on the tick where
//          the count reaches target. The count restarts by itself on expire.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   UnitTick   one-cycle time-unit pulse
//   clear      hold the count at zero (also masks expire)
//   target     length in unit ticks, 1..15
//   expire     combinational pulse, coincident with the terminal tick
module morse_unit_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       UnitTick,
  input  logic       clear,
  input  logic [3:0] target,
  output logic       expire
);

  logic [3:0] count_q, count_d;

  assign expire = UnitTick && !clear && (count_q == target - 4'd1);

  always_comb begin
    count_d = count_q;
    if (clear || expire) begin
      count_d = '0;
    end else if (UnitTick) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/morse_tx.sv
// Purpose: plays one Morse letter on a registered key line, timed in unit ticks.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   UnitTick   one-cycle pulse per time unit
//   Abort      synchronous cancel (ignored in IDLE)
//   load       morse_if slave: LoadValid/LoadReady/SymLen/SymBits
//   MorseOut   key line, 1 = mark
//   Busy       state != IDLE
//   Done       one-cycle pulse when the trailing letter gap completes
//
// state | meaning
// IDLE  | waiting for a letter, LoadReady=1
// SYNC  | letter captured, waiting for the first tick to align to the unit grid
// MARK  | key down for DOT_UNITS or DASH_UNITS
// SGAP  | space between symbols of a letter
// LGAP  | trailing letter gap; Done fires when it ends
module morse_tx
  import morse_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   UnitTick,
  input  logic   Abort,
  morse_if.slave load,
  output logic   MorseOut,
  output logic   Busy,
  output logic   Done
);

  logic [2:0]         state_q, state_d;
  logic [MAX_LEN-1:0] shreg_q, shreg_d;
  logic [2:0]         rem_q, rem_d;
  logic               out_q, out_d;
  logic               done_q, done_d;
  logic               ready_q;
  logic               abort_act;
  logic               tmr_clear, tmr_expire;
  logic [3:0]         tmr_target;

  assign abort_act = Abort && (state_q != ST_IDLE);
  // The timer only runs inside timed states; the sync tick itself is not counted.
  assign tmr_clear = (state_q == ST_IDLE) || (state_q == ST_SYNC) || abort_act;

  always_comb begin
    tmr_target = 4'(DOT_UNITS);
    case (state_q)
      ST_MARK: tmr_target = shreg_q[0] ? 4'(DASH_UNITS) : 4'(DOT_UNITS);
      ST_SGAP: tmr_target = 4'(SYM_GAP_UNITS);
      ST_LGAP: tmr_target = 4'(LETTER_GAP_UNITS);
      default: tmr_target = 4'(DOT_UNITS);
    endcase
  end

  morse_unit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .UnitTick (UnitTick),
    .clear    (tmr_clear),
    .target   (tmr_target),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (abort_act) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      rem_d   = '0;
      out_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load.LoadValid && ready_q) begin
            shreg_d = load.SymBits;
            rem_d   = (load.SymLen > 3'(MAX_LEN)) ? 3'(MAX_LEN) : load.SymLen;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (UnitTick) begin
            if (rem_q != 3'd0) begin
              state_d = ST_MARK;
              out_d   = 1'b1;
            end else begin
              state_d = ST_LGAP;
            end
          end
        end
        ST_MARK: begin
          if (tmr_expire) begin
            shreg_d = shreg_q >> 1;
            rem_d   = rem_q - 3'd1;
            out_d   = 1'b0;
            // rem_q > 1 means symbols remain after this one
            state_d = (rem_q > 3'd1) ? ST_SGAP : ST_LGAP;
          end
        end
        ST_SGAP: begin
          if (tmr_expire) begin
            state_d = ST_MARK;
            out_d   = 1'b1;
          end
        end
        ST_LGAP: begin
          if (tmr_expire) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      done_q  <= done_d;
      // Registered so LoadReady stays low throughout reset.
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign load.LoadReady = ready_q;
  assign MorseOut       = out_q;
  assign Done           = done_q;
  assign Busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: reset, a table of letters, hand-written abort/reset
// sequences, and random letters checked against a per-unit key-line model.
module tb_morse_tx;

  localparam int TB_MAX  = 5;
  localparam int U_DOT   = 1;
  localparam int U_DASH  = 3;
  localparam int U_SGAP  = 1;
  localparam int U_LGAP  = 3;

  logic clk = 1'b0;
  logic rst;
  logic UnitTick;
  logic Abort;
  logic MorseOut, Busy, Done;

  morse_if lif ();

  morse_tx dut (
    .clk      (clk),
    .rst      (rst),
    .UnitTick (UnitTick),
    .Abort    (Abort),
    .load     (lif),
    .MorseOut (MorseOut),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         len;
    logic [4:0] bits;
    int         period;
    bit         tick_acc;
    bit         spur;
    int         exp_mark_clks;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: present tick before the edge, sample #1 after it.
  task automatic cyc(input logic tick);
    @(negedge clk);
    UnitTick = tick;
    @(posedge clk);
    #1;
    UnitTick = 1'b0;
  endtask

  // Model: key-line value for each unit after the sync tick, built from the
  // Morse timing rules; the final tick of the letter gap produces Done.
  task automatic run_letter(input int len, input logic [4:0] bits, input int period,
                            input bit tick_acc, input bit spur, input int exp_mark,
                            input string tag);
    logic q[$];
    int n, marks, budget, expv;
    n = (len > TB_MAX) ? TB_MAX : len;
    for (int i = 0; i < n; i++) begin
      repeat (bits[i] ? U_DASH : U_DOT) q.push_back(1'b1);
      if (i < n - 1) repeat (U_SGAP) q.push_back(1'b0);
    end
    repeat (U_LGAP) q.push_back(1'b0);
    if (exp_mark < 0) begin
      exp_mark = 0;
      foreach (q[k]) if (q[k]) exp_mark += period;
    end

    budget = 0;
    while (!lif.LoadReady && budget < 20) begin
      cyc(1'b0);
      budget++;
    end
    chk({tag, " ready_before_load"}, int'(lif.LoadReady), 1);

    lif.LoadValid = 1'b1;
    lif.SymLen    = 3'(len);
    lif.SymBits   = bits;
    cyc(tick_acc);
    lif.LoadValid = 1'b0;
    lif.SymBits   = ~bits;
    chk({tag, " busy_after_accept"}, int'(Busy), 1);
    chk({tag, " ready_after_accept"}, int'(lif.LoadReady), 0);

    marks = 0;
    for (int t = 0; t <= q.size(); t++) begin
      if (t == 0) expv = 0;
      else expv = int'(q[t-1]);
      for (int c = 0; c < period - 1; c++) begin
        cyc(1'b0);
        chk({tag, " key"}, int'(MorseOut), expv);
        chk({tag, " done_early"}, int'(Done), 0);
        marks += int'(MorseOut);
      end
      if (spur && t == 2) begin
        lif.LoadValid = 1'b1;
        lif.SymLen    = 3'd1;
      end
      cyc(1'b1);
      lif.LoadValid = 1'b0;
      if (t < q.size()) begin
        chk({tag, " key"}, int'(MorseOut), int'(q[t]));
        chk({tag, " done_early"}, int'(Done), 0);
        marks += int'(MorseOut);
      end else begin
        chk({tag, " done"}, int'(Done), 1);
        chk({tag, " ready_at_done"}, int'(lif.LoadReady), 1);
        chk({tag, " busy_at_done"}, int'(Busy), 0);
        chk({tag, " key_at_done"}, int'(MorseOut), 0);
      end
    end
    cyc(1'b0);
    chk({tag, " done_one_cycle"}, int'(Done), 0);
    chk({tag, " mark_clocks"}, marks, exp_mark);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, 5'b00010, 4, 1'b0, 1'b0, 16};  // A
    vecs[1] = '{5, 5'b11111, 4, 1'b0, 1'b0, 60};  // 0
    vecs[2] = '{0, 5'b00000, 4, 1'b0, 1'b0, 0};   // word space
    vecs[3] = '{7, 5'b00000, 4, 1'b0, 1'b0, 20};  // clamped, five dots
    vecs[4] = '{7, 5'b11111, 2, 1'b0, 1'b0, 30};  // clamped, five dashes
    vecs[5] = '{3, 5'b00101, 5, 1'b1, 1'b0, 35};  // K, tick on accept edge
    vecs[6] = '{4, 5'b01011, 3, 1'b0, 1'b1, 30};  // Q, spurious LoadValid

    rst = 1'b0;
    UnitTick = 1'b0;
    Abort = 1'b0;
    lif.LoadValid = 1'b1;
    lif.SymLen = 3'd2;
    lif.SymBits = 5'b00010;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      chk("rst key", int'(MorseOut), 0);
      chk("rst busy", int'(Busy), 0);
      chk("rst done", int'(Done), 0);
      chk("rst ready", int'(lif.LoadReady), 0);
    end
    lif.LoadValid = 1'b0;
    rst = 1'b1;
    cyc(1'b0);
    chk("ready after release", int'(lif.LoadReady), 1);
    chk("busy after release", int'(Busy), 0);

    for (int v = 0; v < 7; v++) begin
      run_letter(vecs[v].len, vecs[v].bits, vecs[v].period, vecs[v].tick_acc,
                 vecs[v].spur, vecs[v].exp_mark_clks, $sformatf("vec%0d", v));
    end

    // Abort coincident with the tick starting the second unit of a dash.
    lif.LoadValid = 1'b1; lif.SymLen = 3'd1; lif.SymBits = 5'b00001;
    cyc(1'b0);
    lif.LoadValid = 1'b0;
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk("abort key before", int'(MorseOut), 1);
    repeat (3) cyc(1'b0);
    Abort = 1'b1;
    cyc(1'b1);
    Abort = 1'b0;
    chk("abort key", int'(MorseOut), 0);
    chk("abort busy", int'(Busy), 0);
    chk("abort ready", int'(lif.LoadReady), 1);
    for (int i = 0; i < 24; i++) begin
      cyc((i % 4) == 3);
      chk("abort no done", int'(Done), 0);
      chk("abort quiet", int'(MorseOut), 0);
    end

    // Reset asserted while in the gap between the two dots of 'I'.
    lif.LoadValid = 1'b1; lif.SymLen = 3'd2; lif.SymBits = 5'b00000;
    cyc(1'b0);
    lif.LoadValid = 1'b0;
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk("rstmid key mark", int'(MorseOut), 1);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk("rstmid key gap", int'(MorseOut), 0);
    cyc(1'b0);
    rst = 1'b0;
    cyc(1'b0);
    chk("rstmid busy", int'(Busy), 0);
    chk("rstmid ready", int'(lif.LoadReady), 0);
    chk("rstmid done", int'(Done), 0);
    chk("rstmid key", int'(MorseOut), 0);
    rst = 1'b1;
    cyc(1'b0);
    chk("rstmid ready after", int'(lif.LoadReady), 1);
    for (int i = 0; i < 16; i++) begin
      cyc((i % 4) == 3);
      chk("rstmid no done", int'(Done), 0);
      chk("rstmid quiet", int'(MorseOut), 0);
    end

    for (int r = 0; r < 25; r++) begin
      run_letter(int'($urandom_range(0, 7)), 5'($urandom), int'($urandom_range(1, 5)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
                 $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
